// File: rtl/spi_cfg_arbiter_if.sv
// Bundle of requester-side and SPI-master-side signals around the
// configuration SPI arbiter. The slave modport is the arbiter's view.
// The master modport is the view of the surrounding logic, which drives
// the requests and the SPI master responses.
interface spi_cfg_arbiter_if #(
  parameter int NUM_REQ         = 3,
  parameter int MOSI_DATA_WIDTH = 24,
  parameter int MISO_DATA_WIDTH = 8
);
  // Requester side
  logic [NUM_REQ-1:0]                 req_i;
  logic [NUM_REQ-1:0]                 grant_o;
  logic [NUM_REQ-1:0]                 req_wr_cmd_i;
  logic [NUM_REQ-1:0]                 req_rd_cmd_i;
  logic [NUM_REQ*MOSI_DATA_WIDTH-1:0] req_wr_data_i;
  logic [MISO_DATA_WIDTH:0]           req_rd_data_o;
  logic [NUM_REQ-1:0]                 req_busy_o;

  // SPI master side
  logic                               spi_wr_cmd_o;
  logic                               spi_rd_cmd_o;
  logic [MOSI_DATA_WIDTH-1:0]         spi_wr_data_o;
  logic [MISO_DATA_WIDTH:0]           spi_rd_data_i;
  logic                               spi_busy_i;
  logic                               spi_cs_n_i;

  // Device chip-selects and protocol error
  logic [NUM_REQ-1:0]                 dev_cs_n_o;
  logic                               err_o;

  modport slave (
    input  req_i, req_wr_cmd_i, req_rd_cmd_i, req_wr_data_i,
    input  spi_rd_data_i, spi_busy_i, spi_cs_n_i,
    output grant_o, req_rd_data_o, req_busy_o,
    output spi_wr_cmd_o, spi_rd_cmd_o, spi_wr_data_o,
    output dev_cs_n_o, err_o
  );

  modport master (
    output req_i, req_wr_cmd_i, req_rd_cmd_i, req_wr_data_i,
    output spi_rd_data_i, spi_busy_i, spi_cs_n_i,
    input  grant_o, req_rd_data_o, req_busy_o,
    input  spi_wr_cmd_o, spi_rd_cmd_o, spi_wr_data_o,
    input  dev_cs_n_o, err_o
  );
endinterface

// File: rtl/spi_cfg_arbiter.sv
// Shares the single board SPI master between the AD9517 configurator (0)
// and the two AD9434 configurators (1, 2). One requester owns the bus per
// session, and ownership rotates round-robin. The owner's commands and data
// go straight to the master, and the master's chip-select is steered to the
// owner's device only. A fixed idle gap follows each session, and all
// chip-selects are held high during that gap.
//
// Handshake: a requester holds req_i high for the whole session. It may
// pulse a write or read command only while its own req_busy_o is 0. The
// arbiter does not queue anything. A command that does not come from the
// current owner is dropped, and err_o pulses one cycle later.
module spi_cfg_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int MOSI_DATA_WIDTH = 24,
  parameter int MISO_DATA_WIDTH = 8,
  parameter int GAP_CYCLES      = 4
) (
  input  logic                clk,
  input  logic                rstn,
  spi_cfg_arbiter_if.slave    bus,
  output logic [1:0]          dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_DRAIN = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [3:0]         gap_q, gap_d;
  logic               err_q, err_d;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               fwd_en;

  // Round-robin pick: first active request starting at rr_q, wrapping around.
  always_comb begin
    int k;
    k          = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!pick_valid && bus.req_i[k]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(k);
      end
    end
  end

  // Session FSM: next state, grant, owner index, rotation pointer, gap count.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d = S_OWN;
          gidx_d  = pick_idx;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
        end
      end
      S_OWN: begin
        if (!bus.req_i[gidx_q]) begin
          rr_d = (gidx_q == IDX_W'(NUM_REQ-1)) ? '0 : gidx_q + IDX_W'(1);
          if (bus.spi_busy_i) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_GAP;
            grant_d = '0;
            gap_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (!bus.spi_busy_i) begin
          state_d = S_GAP;
          grant_d = '0;
          gap_d   = '0;
        end
      end
      S_GAP: begin
        if (gap_q == 4'(GAP_CYCLES-1)) state_d = S_IDLE;
        else                           gap_d   = gap_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A command from any requester that does not hold the grant is an error.
  // The owner's own command in its release cycle is only masked.
  always_comb begin
    err_d = |((bus.req_wr_cmd_i | bus.req_rd_cmd_i) & ~grant_q);
  end

  // State and session registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  // Forward the owner's command path. Commands pass only while the owner
  // still holds its request. Once it drops, they are masked.
  always_comb begin
    fwd_en            = (state_q == S_OWN) && bus.req_i[gidx_q];
    bus.spi_wr_cmd_o  = fwd_en & bus.req_wr_cmd_i[gidx_q];
    bus.spi_rd_cmd_o  = fwd_en & bus.req_rd_cmd_i[gidx_q];
    bus.spi_wr_data_o = '0;
    if (state_q == S_OWN)
      bus.spi_wr_data_o = bus.req_wr_data_i[int'(gidx_q)*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
  end

  // grant_q is non-zero only in OWN/DRAIN. It therefore alone selects which
  // chip-select and busy bit follow the master. All other bits stay high.
  assign bus.dev_cs_n_o    = ~grant_q | {NUM_REQ{bus.spi_cs_n_i}};
  assign bus.req_busy_o    = ~grant_q | {NUM_REQ{bus.spi_busy_i}};
  assign bus.req_rd_data_o = bus.spi_rd_data_i;
  assign bus.grant_o       = grant_q;
  assign bus.err_o         = err_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// Directed bench for spi_cfg_arbiter (NUM_REQ=3, GAP_CYCLES=4). Inputs are
// driven 1 ns after the rising edge. Outputs are checked either at that
// point or a few ns later, once the combinational paths have settled.
module tb_spi_cfg_arbiter;

  localparam int NR = 3;
  localparam int MW = 24;
  localparam int RW = 8;

  logic       clk;
  logic       rstn;
  logic [1:0] dbg_state;
  int         checks;
  int         failures;

  spi_cfg_arbiter_if #(.NUM_REQ(NR), .MOSI_DATA_WIDTH(MW), .MISO_DATA_WIDTH(RW)) bus ();

  spi_cfg_arbiter #(
    .NUM_REQ(NR), .MOSI_DATA_WIDTH(MW), .MISO_DATA_WIDTH(RW), .GAP_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // 20 MHz clock
  initial clk = 1'b0;
  always #25 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Covers the four cycles after the first GAP cycle: three more GAP cycles
  // and the IDLE cycle. The chip-select from the master is held low, and
  // the device chip-selects must stay high regardless. The next edge must
  // then grant exp_g.
  task automatic gap_then_grant(input string tag, input logic [2:0] exp_g);
    bus.spi_cs_n_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk({tag, "_gap_grant"}, 32'(bus.grant_o), 32'h0);
      chk({tag, "_gap_cs"}, 32'(bus.dev_cs_n_o), 32'h7);
    end
    bus.spi_cs_n_i = 1'b1;
    tick;
    chk({tag, "_grant"}, 32'(bus.grant_o), 32'(exp_g));
    chk({tag, "_own"}, 32'(dbg_state), 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn                 = 1'b0;
    bus.req_i            = '0;
    bus.req_wr_cmd_i     = '0;
    bus.req_rd_cmd_i     = '0;
    bus.req_wr_data_i    = '0;
    bus.spi_rd_data_i    = '0;
    bus.spi_busy_i       = 1'b0;
    bus.spi_cs_n_i       = 1'b1;

    // Reset values. A low chip-select from the master must be ignored.
    #60;
    bus.spi_cs_n_i = 1'b0;
    #5;
    chk("rst_grant", 32'(bus.grant_o), 32'h0);
    chk("rst_cs", 32'(bus.dev_cs_n_o), 32'h7);
    chk("rst_wr_cmd", 32'(bus.spi_wr_cmd_o), 32'h0);
    chk("rst_rd_cmd", 32'(bus.spi_rd_cmd_o), 32'h0);
    chk("rst_wr_data", 32'(bus.spi_wr_data_o), 32'h0);
    chk("rst_busy", 32'(bus.req_busy_o), 32'h7);
    chk("rst_err", 32'(bus.err_o), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);
    bus.spi_cs_n_i = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Single request from ADC0. The grant appears on the next edge, and
    // the write is forwarded in the same cycle.
    bus.req_i = 3'b010;
    tick;
    chk("t1_grant", 32'(bus.grant_o), 32'h2);
    chk("t1_state", 32'(dbg_state), 32'h1);
    bus.req_wr_cmd_i  = 3'b010;
    bus.req_wr_data_i = {24'h0, 24'h000F3C, 24'h0};
    bus.spi_cs_n_i    = 1'b0;
    #10;
    chk("t1_wr_cmd", 32'(bus.spi_wr_cmd_o), 32'h1);
    chk("t1_wr_data", 32'(bus.spi_wr_data_o), 32'h000F3C);
    chk("t1_cs_low", 32'(bus.dev_cs_n_o), 32'h5);
    chk("t1_busy", 32'(bus.req_busy_o), 32'h5);
    bus.spi_cs_n_i = 1'b1;
    #5;
    chk("t1_cs_high", 32'(bus.dev_cs_n_o), 32'h7);
    tick;
    bus.req_wr_cmd_i = '0;
    #10;
    chk("t1_wr_cmd_off", 32'(bus.spi_wr_cmd_o), 32'h0);
    chk("t1_no_err", 32'(bus.err_o), 32'h0);

    // The owner drops its request and pulses a command in the same cycle.
    // The command is masked and raises no error. AD9517 is already waiting.
    bus.req_i        = 3'b001;
    bus.req_wr_cmd_i = 3'b010;
    #10;
    chk("t1_drop_mask", 32'(bus.spi_wr_cmd_o), 32'h0);
    tick;
    bus.req_wr_cmd_i = '0;
    chk("t1_drop_err", 32'(bus.err_o), 32'h0);
    chk("t1_gap_state", 32'(dbg_state), 32'h3);
    chk("t1_gap_grant0", 32'(bus.grant_o), 32'h0);
    gap_then_grant("t1", 3'b001);

    // ADC1 issues a write while AD9517 owns the bus.
    bus.req_wr_data_i = {24'hABCDEF, 24'h0, 24'h123456};
    bus.req_wr_cmd_i  = 3'b100;
    #10;
    chk("t2_blocked", 32'(bus.spi_wr_cmd_o), 32'h0);
    chk("t2_data_owner", 32'(bus.spi_wr_data_o), 32'h123456);
    chk("t2_busy", 32'(bus.req_busy_o), 32'h6);
    tick;
    bus.req_wr_cmd_i = '0;
    chk("t2_err_pulse", 32'(bus.err_o), 32'h1);
    tick;
    chk("t2_err_clear", 32'(bus.err_o), 32'h0);

    // AD9517 releases while the master is still busy. The arbiter moves to
    // DRAIN and holds the grant and the chip-select steering.
    bus.spi_busy_i = 1'b1;
    bus.req_i      = 3'b110;
    #10;
    chk("t3_busy_all", 32'(bus.req_busy_o), 32'h7);
    tick;
    chk("t3_drain_state", 32'(dbg_state), 32'h2);
    chk("t3_drain_grant", 32'(bus.grant_o), 32'h1);
    bus.spi_cs_n_i = 1'b0;
    #5;
    chk("t3_drain_cs", 32'(bus.dev_cs_n_o), 32'h6);
    tick;
    chk("t3_drain_hold", 32'(bus.grant_o), 32'h1);
    bus.spi_busy_i = 1'b0;
    tick;
    chk("t3_gap_state", 32'(dbg_state), 32'h3);
    chk("t3_gap_grant0", 32'(bus.grant_o), 32'h0);
    gap_then_grant("t3", 3'b010);

    // ADC0 issues a read. The read data is broadcast, and busy follows the master.
    bus.req_rd_cmd_i  = 3'b010;
    bus.spi_rd_data_i = 9'h1A5;
    #10;
    chk("t4_rd_cmd", 32'(bus.spi_rd_cmd_o), 32'h1);
    chk("t4_rd_data", 32'(bus.req_rd_data_o), 32'h1A5);
    chk("t4_busy_idle", 32'(bus.req_busy_o), 32'h5);
    bus.spi_busy_i = 1'b1;
    #5;
    chk("t4_busy_set", 32'(bus.req_busy_o), 32'h7);
    tick;
    bus.req_rd_cmd_i = '0;
    bus.spi_busy_i   = 1'b0;
    #5;
    chk("t4_busy_clr", 32'(bus.req_busy_o), 32'h5);
    chk("t4_rd_cmd_off", 32'(bus.spi_rd_cmd_o), 32'h0);

    // ADC0 releases, and ADC1 is next in rotation.
    bus.req_i = 3'b100;
    tick;
    chk("t5_gap_state", 32'(dbg_state), 32'h3);
    gap_then_grant("t5", 3'b100);

    // Reset is asserted mid-DRAIN. The outputs must clear without waiting for a clock edge.
    bus.spi_busy_i = 1'b1;
    bus.req_i      = 3'b000;
    tick;
    chk("t6_drain_state", 32'(dbg_state), 32'h2);
    bus.spi_cs_n_i = 1'b0;
    #5;
    chk("t6_drain_cs", 32'(bus.dev_cs_n_o), 32'h3);
    #5;
    rstn = 1'b0;
    #2;
    chk("t6_rst_grant", 32'(bus.grant_o), 32'h0);
    chk("t6_rst_cs", 32'(bus.dev_cs_n_o), 32'h7);
    chk("t6_rst_busy", 32'(bus.req_busy_o), 32'h7);
    chk("t6_rst_state", 32'(dbg_state), 32'h0);

    // After reset, all three request at once. The grant order must be 0, 1, 2.
    bus.req_i      = 3'b111;
    bus.spi_busy_i = 1'b0;
    bus.spi_cs_n_i = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick;
    chk("t7_first", 32'(bus.grant_o), 32'h1);
    bus.req_i = 3'b110;
    tick;
    chk("t7_gap_a", 32'(dbg_state), 32'h3);
    gap_then_grant("t7a", 3'b010);
    bus.req_i = 3'b100;
    tick;
    chk("t7_gap_b", 32'(dbg_state), 32'h3);
    gap_then_grant("t7b", 3'b100);
    bus.req_i = 3'b000;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_cfg_arbiter.md
# spi_cfg_arbiter

Shares the single board SPI master (one SCLK/SDIO pair) between the configuration requesters: the AD9517 clock-chip configurator and the two AD9434 ADC configurators. Grants the bus to one requester per session with round-robin fairness, multiplexes that requester's command/data toward the SPI master, and steers the master's chip-select to that device's CS_N pin only. Runs on the 20 MHz configuration clock domain.

## Interface
- NUM_REQ, 3, number of requesters; index 0 = AD9517, 1 = ADC0, 2 = ADC1
- MOSI_DATA_WIDTH, 24, SPI write word width
- MISO_DATA_WIDTH, 8, SPI read width; read bus is MISO_DATA_WIDTH+1 bits
- GAP_CYCLES, 4, idle clk cycles (1..15) between release and next grant, all CS_N high
- clk  in  1  configuration clock (20 MHz)
- rstn  in  1  reset, asynchronous, active-low
- req_i  in  NUM_REQ  session request per requester, level, held for whole session
- grant_o  out  NUM_REQ  one-hot (or zero) session grant
- req_wr_cmd_i  in  NUM_REQ  write-command pulse per requester
- req_rd_cmd_i  in  NUM_REQ  read-command pulse per requester
- req_wr_data_i  in  NUM_REQ*MOSI_DATA_WIDTH  packed write words, requester k at [k*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH]
- req_rd_data_o  out  MISO_DATA_WIDTH+1  master read data, broadcast to all
- req_busy_o  out  NUM_REQ  per-requester busy: spi_busy_i when granted, 1 otherwise
- spi_wr_cmd_o  out  1  to master
- spi_rd_cmd_o  out  1  to master
- spi_wr_data_o  out  MOSI_DATA_WIDTH  to master
- spi_rd_data_i  in  MISO_DATA_WIDTH+1  from master
- spi_busy_i  in  1  from master
- spi_cs_n_i  in  1  master chip-select
- dev_cs_n_o  out  NUM_REQ  device chip-selects, active-low
- err_o  out  1  one-cycle pulse: command from a non-granted requester

## Operation
- States: IDLE, OWN, DRAIN, GAP.
- IDLE: if any req_i set, grant highest-priority requester in round-robin order starting at rr_ptr; register grant_o, go OWN. Else stay.
- OWN: grant_o[g]=1. spi_wr_cmd_o/spi_rd_cmd_o/spi_wr_data_o = requester g's inputs (combinational mux from registered grant). dev_cs_n_o[g]=spi_cs_n_i, other bits 1. Stays while req_i[g]=1.
- OWN, req_i[g] falls: commands from g masked from that cycle. If spi_busy_i=1 go DRAIN, else go GAP. rr_ptr <= (g+1) mod NUM_REQ.
- DRAIN: grant_o held, CS steering held, commands masked; on spi_busy_i=0 go GAP.
- GAP: grant_o=0, all dev_cs_n_o=1, commands 0; count GAP_CYCLES then IDLE.
- Commands from non-granted requesters never reach the master; each such cycle pulses err_o (registered, next cycle).
- spi_cs_n_i low outside OWN/DRAIN is ignored (all dev_cs_n_o stay 1).
- Requesters must issue commands only when own req_busy_o=0; arbiter does not queue commands.

## Timing
- Reset values: state IDLE, grant_o 0, rr_ptr 0, dev_cs_n_o all 1, spi_*_cmd_o 0, spi_wr_data_o 0, req_busy_o all 1, err_o 0.
- Grant latency: req_i set at edge t (IDLE) -> grant_o at t+1; command issued in cycle t+1 forwarded same cycle (0 added latency).
- req_busy_o[g] combinational from spi_busy_i while granted.
- Release to next grant: minimum GAP_CYCLES+2 cycles after req_i[g] falls with master idle.
- Simultaneous requests: round-robin from rr_ptr; after reset, order 0,1,2.
- req_i[g] drop and command pulse same cycle: command masked, err_o not pulsed.
- rstn low mid-transfer: all outputs to reset values immediately (async); master is reset by same rstn.

## Test plan
- Single request: req_i=3'b010, wr_cmd with data 24'h000F3C -> grant_o=3'b010 next cycle, spi_wr_data_o=24'h000F3C, dev_cs_n_o=3'b1x1 following spi_cs_n_i.
- All three request at once after reset -> grants in order 0,1,2, each separated by ≥GAP_CYCLES cycles with dev_cs_n_o=3'b111.
- Requester 0 drops req while spi_busy_i=1 -> DRAIN, grant_o=3'b001 held until busy falls, then GAP, then requester 1 granted.
- Requester 2 pulses wr_cmd while requester 0 granted -> spi_wr_cmd_o stays 0, err_o single pulse, req_busy_o[2]=1.
- Read: granted requester 1 issues rd_cmd, master returns 9'h1A5 -> req_rd_data_o=9'h1A5, req_busy_o[1] tracks spi_busy_i.
- rstn pulled low mid-DRAIN -> grant_o=0, dev_cs_n_o=3'b111 immediately; after release, fresh arbitration from requester 0.
